// File: rtl/qoa_slice_loader.sv
// rtl/qoa_slice_loader.sv - SPI byte-stream command parser feeding the QOA dequant/LMS core
//
// Purpose: decodes opcode + 8-byte payloads. HIST/WEIGHT payloads become four
// 16-bit LMS register write pulses. SLICE payloads are captured as a 64-bit
// slice and streamed out as 20 three-bit residual codes over valid/ready.
//
// Optional feature macro: QOA_LOADER_ERR_EN (sticky protocol error flag).
//
// Ports:
//   sys_clk, sys_rst_n     clock, asynchronous active-low reset
//   data_rdy, spi_in       one-cycle byte strobe and received byte
//   wr_en/sel/idx/data     LMS register write (sel 0 = history, 1 = weight)
//   res_valid/ready        residual handshake
//   res_sf, res_qr, res_last  scalefactor, residual code, last-of-slice marker
//   busy                   parser not idle
//   err                    sticky protocol error (0 unless macro defined)
module qoa_slice_loader #(
   parameter logic [7:0] OP_HIST   = 8'h01,
   parameter logic [7:0] OP_WEIGHT = 8'h02,
   parameter logic [7:0] OP_SLICE  = 8'h03
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        data_rdy,
   input  logic [7:0]  spi_in,
   output logic        wr_en,
   output logic        wr_sel,
   output logic [1:0]  wr_idx,
   output logic [15:0] wr_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [3:0]  res_sf,
   output logic [2:0]  res_qr,
   output logic        res_last,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_EMIT = 2'd2} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_op_weight;
   logic        r_op_slice;
   logic [2:0]  r_byte_cnt;
   logic [7:0]  r_hi;
   logic [63:0] r_slice;
   logic [4:0]  r_res_cnt;
   logic        r_wr_en;
   logic        r_wr_sel;
   logic [1:0]  r_wr_idx;
   logic [15:0] r_wr_data;

   logic w_is_op;
   logic w_hs;

   assign w_is_op = (spi_in == OP_HIST) || (spi_in == OP_WEIGHT) || (spi_in == OP_SLICE);
   assign w_hs    = res_valid && res_ready;

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (data_rdy && w_is_op) w_next = S_LOAD;
         S_LOAD: if (data_rdy && (r_byte_cnt == 3'd7)) w_next = r_op_slice ? S_EMIT : S_IDLE;
         S_EMIT: if (w_hs && (r_res_cnt == 5'd19)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic; residual fields are zeroed outside EMIT so idle outputs read 0
   always_comb begin
      busy      = (r_state != S_IDLE);
      res_valid = (r_state == S_EMIT);
      res_last  = res_valid && (r_res_cnt == 5'd19);
      res_sf    = res_valid ? r_slice[63:60] : 4'd0;
      res_qr    = res_valid ? r_slice[59:57] : 3'd0;
   end

   // Payload datapath
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_op_weight <= 1'b0;
         r_op_slice  <= 1'b0;
         r_byte_cnt  <= 3'd0;
         r_hi        <= 8'd0;
         r_slice     <= 64'd0;
         r_res_cnt   <= 5'd0;
         r_wr_en     <= 1'b0;
         r_wr_sel    <= 1'b0;
         r_wr_idx    <= 2'd0;
         r_wr_data   <= 16'd0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (data_rdy && w_is_op) begin
                  r_op_weight <= (spi_in == OP_WEIGHT);
                  r_op_slice  <= (spi_in == OP_SLICE);
                  r_byte_cnt  <= 3'd0;
               end
            end
            S_LOAD: begin
               if (data_rdy) begin
                  // 3-bit counter wraps to 0 after byte 7, ready for the next command
                  r_byte_cnt <= r_byte_cnt + 3'd1;
                  if (r_op_slice) begin
                     r_slice <= {r_slice[55:0], spi_in};
                     if (r_byte_cnt == 3'd7) r_res_cnt <= 5'd0;
                  end else if (!r_byte_cnt[0]) begin
                     r_hi <= spi_in;
                  end else begin
                     r_wr_en   <= 1'b1;
                     r_wr_sel  <= r_op_weight;
                     r_wr_idx  <= r_byte_cnt[2:1];
                     r_wr_data <= {r_hi, spi_in};
                  end
               end
            end
            S_EMIT: begin
               // Scalefactor stays put; residual field shifts up one code per handshake
               if (w_hs) begin
                  r_slice[59:0] <= {r_slice[56:0], 3'b000};
                  r_res_cnt     <= r_res_cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign wr_en   = r_wr_en;
   assign wr_sel  = r_wr_sel;
   assign wr_idx  = r_wr_idx;
   assign wr_data = r_wr_data;

`ifdef QOA_LOADER_ERR_EN
   logic r_err;
   logic w_err_evt;

   // Unknown opcode in IDLE (0x00 is a legal NOP) or any byte during EMIT
   assign w_err_evt = data_rdy &&
                      (((r_state == S_IDLE) && !w_is_op && (spi_in != 8'h00)) ||
                       (r_state == S_EMIT));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)     r_err <= 1'b0;
      else if (w_err_evt) r_err <= 1'b1;
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qoa_slice_loader.sv
// tb/tb_qoa_slice_loader.sv - directed self-checking bench for qoa_slice_loader
module tb_qoa_slice_loader;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        data_rdy;
   logic [7:0]  spi_in;
   logic        wr_en;
   logic        wr_sel;
   logic [1:0]  wr_idx;
   logic [15:0] wr_data;
   logic        res_valid;
   logic        res_ready;
   logic [3:0]  res_sf;
   logic [2:0]  res_qr;
   logic        res_last;
   logic        busy;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;

`ifdef QOA_LOADER_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   localparam logic [63:0] SLICE_A = 64'hA053_9772_E53A_C31F;
   localparam logic [63:0] SLICE_B = 64'h5FAC_0123_4567_89AB;

   qoa_slice_loader dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .data_rdy  (data_rdy),
      .spi_in    (spi_in),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sf    (res_sf),
      .res_qr    (res_qr),
      .res_last  (res_last),
      .busy      (busy),
      .err       (err)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge sys_clk);
   endtask

   // Present one byte for exactly one posedge; returns at the following negedge
   task automatic send_byte(input logic [7:0] b);
      data_rdy = 1'b1;
      spi_in   = b;
      tick();
      data_rdy = 1'b0;
      spi_in   = 8'h00;
   endtask

   task automatic pulse_reset();
      sys_rst_n = 1'b0;
      tick();
      sys_rst_n = 1'b1;
      tick();
   endtask

   // op + 8 payload bytes; exp_words holds the four expected 16-bit writes, idx0 in the MSBs
   task automatic load_regs(input logic [7:0] op, input logic [63:0] payload,
                            input logic sel, input logic [63:0] exp_words);
      logic [7:0] b;
      send_byte(op);
      check("busy_after_op", busy, 1);
      for (int i = 0; i < 8; i++) begin
         b = payload[63-8*i -: 8];
         send_byte(b);
         if (i % 2 == 1) begin
            check("wr_en_pulse", wr_en, 1);
            check("wr_sel", wr_sel, sel);
            check("wr_idx", wr_idx, i / 2);
            check("wr_data", wr_data, exp_words[63-16*(i/2) -: 16]);
         end else begin
            check("wr_en_low", wr_en, 0);
         end
         check("busy_load", busy, (i == 7) ? 0 : 1);
      end
      tick();
      check("wr_en_after", wr_en, 0);
      check("busy_idle", busy, 0);
   endtask

   task automatic load_slice(input logic [63:0] sl);
      send_byte(8'h03);
      for (int i = 0; i < 8; i++) begin
         check("slice_no_valid", res_valid, 0);
         send_byte(sl[63-8*i -: 8]);
      end
   endtask

   // Residual k is sl[59-3k -: 3]; scalefactor is sl[63:60]
   task automatic emit_check(input logic [63:0] sl, input bit stall);
      logic [2:0] exp_qr;
      for (int k = 0; k < 20; k++) begin
         exp_qr = sl[59-3*k -: 3];
         check("res_valid", res_valid, 1);
         check("res_sf", res_sf, sl[63:60]);
         check("res_qr", res_qr, exp_qr);
         check("res_last", res_last, (k == 19) ? 1 : 0);
         if (stall) begin
            res_ready = 1'b0;
            tick();
            check("stall_valid", res_valid, 1);
            check("stall_qr", res_qr, exp_qr);
            check("stall_last", res_last, (k == 19) ? 1 : 0);
         end
         res_ready = 1'b1;
         tick();
      end
      check("valid_after_last", res_valid, 0);
      check("busy_after_last", busy, 0);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      data_rdy  = 1'b0;
      spi_in    = 8'h00;
      res_ready = 1'b0;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_valid", res_valid, 0);
      check("rst_qr", res_qr, 0);
      check("rst_err", err, 0);
      sys_rst_n = 1'b1;
      tick();

      // NOP keeps parser idle
      send_byte(8'h00);
      check("nop_busy", busy, 0);
      check("nop_err", err, 0);

      load_regs(8'h01, 64'h0011_2233_8000_7FFF, 1'b0, 64'h0011_2233_8000_7FFF);
      load_regs(8'h02, 64'h0000_FFFF_4000_0001, 1'b1, 64'h0000_FFFF_4000_0001);

      // Full-rate emit
      res_ready = 1'b1;
      load_slice(SLICE_A);
      emit_check(SLICE_A, 1'b0);

      // Stalled emit
      res_ready = 1'b0;
      load_slice(SLICE_A);
      emit_check(SLICE_A, 1'b1);

      res_ready = 1'b1;
      load_slice(SLICE_B);
      emit_check(SLICE_B, 1'b0);

      // Unknown opcode in IDLE
      send_byte(8'h5A);
      check("unk_busy", busy, 0);
      check("unk_err", err, EXP_ERR);
      tick();
      check("unk_err_sticky", err, EXP_ERR);
      pulse_reset();
      check("err_cleared", err, 0);

      // Byte during EMIT is dropped
      res_ready = 1'b0;
      load_slice(SLICE_A);
      send_byte(8'h01);
      check("ovr_busy", busy, 1);
      check("ovr_valid", res_valid, 1);
      check("ovr_qr", res_qr, SLICE_A[59:57]);
      check("ovr_err", err, EXP_ERR);
      emit_check(SLICE_A, 1'b0);
      load_regs(8'h01, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h1234_5678_9ABC_DEF0);
      check("ovr_err_sticky", err, EXP_ERR);

      // Asynchronous reset mid-emit
      res_ready = 1'b0;
      load_slice(SLICE_B);
      tick();
      check("pre_rst_valid", res_valid, 1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("arst_valid", res_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_err", err, 0);
      check("arst_last", res_last, 0);
      tick();
      sys_rst_n = 1'b1;
      tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", res_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
